// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the byte-serial multi-precision add/subtract sequencer.
package multiword_add_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multiword_add_seq_prefixadder8.sv
// 8-bit Kogge-Stone prefix adder; carry-in is folded into bit 0's generate term.
module prefixadder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] y,
    output logic       cout,
    output logic       zero
);

    logic [7:0] prop;
    logic [7:0] g0, g1, g2, g3;
    logic [7:0] p0, p1, p2;

    always_comb begin
        prop = a ^ b;
        g0   = a & b;
        g0[0] = (a[0] & b[0]) | (prop[0] & cin);
        p0   = prop;
        // Low bits of each level's propagate are padded with ones; their group
        // already reaches bit 0, so the final generate there is settled.
        g1 = g0 | (p0 & (g0 << 1));
        p1 = p0 & ((p0 << 1) | 8'h01);
        g2 = g1 | (p1 & (g1 << 2));
        p2 = p1 & ((p1 << 2) | 8'h03);
        g3 = g2 | (p2 & (g2 << 4));
        y    = prop ^ {g3[6:0], cin};
        cout = g3[7];
        zero = (y == 8'h00);
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Byte-serial NBYTES-wide add/subtract: walks one 8-bit prefix adder LSB byte first,
// chaining the carry, then commits sum, carry-out, signed overflow and zero.
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic                     sub,
    input  logic                     cin,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    output logic                     busy,
    output logic                     done,
    output logic [BYTE_W*NBYTES-1:0] result,
    output logic                     cout,
    output logic                     ovf,
    output logic                     zero,
    output logic [1:0]               fsm_state
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    // Handshake: a request is taken on a rising edge where start_valid and
    // start_ready are both high; start_ready is high only in IDLE.
    state_t              state, state_next;
    logic [W-1:0]        a_sh, b_sh;
    logic [W-BYTE_W-1:0] partial;
    logic [W-1:0]        combined;
    logic [IDX_W-1:0]    idx;
    logic                carry, zero_acc;
    logic [BYTE_W-1:0]   sum_byte;
    logic                add_cout;
    logic                accept, last;

    prefixadder8 u_adder (
        .a    (a_sh[BYTE_W-1:0]),
        .b    (b_sh[BYTE_W-1:0]),
        .cin  (carry),
        .y    (sum_byte),
        .cout (add_cout),
        .zero ()
    );

    assign accept    = start_valid && (state == S_IDLE);
    assign last      = (idx == IDX_LAST);
    assign combined  = {sum_byte, partial};
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        start_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) state_next = S_DONE;
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh     <= '0;
            b_sh     <= '0;
            partial  <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            zero_acc <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            a_sh     <= a;
            b_sh     <= sub ? ~b : b;
            carry    <= sub ? 1'b1 : cin;
            idx      <= '0;
            zero_acc <= 1'b1;
        end else if (state == S_RUN) begin
            a_sh     <= a_sh >> BYTE_W;
            b_sh     <= b_sh >> BYTE_W;
            partial  <= combined[W-1:BYTE_W];
            carry    <= add_cout;
            zero_acc <= zero_acc & (sum_byte == '0);
            if (last) begin
                // The low bytes of the shift registers now hold the operand MS bytes.
                idx    <= '0;
                result <= combined;
                cout   <= add_cout;
                ovf    <= (a_sh[BYTE_W-1] == b_sh[BYTE_W-1]) && (sum_byte[BYTE_W-1] != a_sh[BYTE_W-1]);
                zero   <= zero_acc & (sum_byte == '0);
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq: cycle-level behavioural model plus
// directed literal cases and randomized traffic.
module tb_multiword_add_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_valid;
    logic         start_ready;
    logic         sub;
    logic         cin;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] result;
    logic         cout, ovf, zero;
    logic [1:0]   fsm_state;

    int errors = 0;
    int checks = 0;

    multiword_add_seq #(.NBYTES(NB)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .sub         (sub),
        .cin         (cin),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .cout        (cout),
        .ovf         (ovf),
        .zero        (zero),
        .fsm_state   (fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: packed {cout, ovf, zero, result}
    function automatic logic [W+2:0] model_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic s, input logic c);
        logic [W:0]   full;
        logic [W-1:0] r;
        logic         co, v;
        if (s) begin
            full = {1'b0, x} - {1'b0, y};
            r    = full[W-1:0];
            co   = ~full[W];
            v    = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        end else begin
            full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
            r    = full[W-1:0];
            co   = full[W];
            v    = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        end
        return {co, v, (r == '0), r};
    endfunction

    logic [W+2:0] exp_q[$];
    logic [W+2:0] held;
    int           m_left  = 0;
    bit           m_valid = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0;
            exp_q.delete();
            held    = '0;
            m_valid = 1;
        end else if (m_valid) begin
            if (m_left > 0) begin
                if (m_left == 2 && exp_q.size() > 0) held = exp_q.pop_front();
                m_left--;
            end else if (start_valid) begin
                exp_q.push_back(model_op(a, b, sub, cin));
                m_left = NB + 1;
            end
        end
    end

    // compare process
    always @(negedge clk) begin
        if (m_valid) begin
            check("start_ready", W'(start_ready), W'(m_left == 0));
            check("busy",        W'(busy),        W'(m_left > 0));
            check("done",        W'(done),        W'(m_left == 1));
            check("result",      result,          held[W-1:0]);
            check("cout",        W'(cout),        W'(held[W+2]));
            check("ovf",         W'(ovf),         W'(held[W+1]));
            check("zero",        W'(zero),        W'(held[W]));
        end
    end

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    // driver tasks
    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (start_ready) break;
        end
        if (k == 20) check({name, "_idle_timeout"}, W'(0), W'(1));
    endtask

    task automatic run_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic s, input logic c, input logic [W-1:0] er,
                          input logic ec, input logic ev, input logic ez);
        int k;
        wait_idle(name);
        a = xa; b = xb; sub = s; cin = c; start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) break;
        end
        check({name, "_latency"}, W'(k), W'(NB + 1));
        check({name, "_result"}, result, er);
        check({name, "_cout"}, W'(cout), W'(ec));
        check({name, "_ovf"},  W'(ovf),  W'(ev));
        check({name, "_zero"}, W'(zero), W'(ez));
    endtask

    initial begin
        reset = 1'b1; start_valid = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_result", result, '0);
        check("reset_flags", W'({cout, ovf, zero, done, busy}), W'(0));
        check("reset_ready", W'(start_ready), W'(1));

        // directed literal cases
        run_op("add_carry_chain", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0);
        run_op("add_wrap",        32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
        run_op("add_ovf",         32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        run_op("add_cin",         32'h12345678, 32'h00000000, 1'b0, 1'b1, 32'h12345679, 1'b0, 1'b0, 1'b0);
        run_op("sub_borrow",      32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_equal",       32'h00000007, 32'h00000007, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
        run_op("sub_ovf",         32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);

        // back-to-back with start_valid held high and operands changing every cycle
        wait_idle("b2b");
        start_valid = 1'b1;
        begin
            int k;
            for (k = 0; k < 30; k++) begin
                a = rand_operand(); b = rand_operand();
                sub = 1'($urandom); cin = 1'($urandom);
                @(negedge clk);
                if (done) break;
            end
            check("b2b_first_done_seen", W'(k < 30), W'(1));
            a = rand_operand(); b = rand_operand();
            @(negedge clk);
            check("b2b_ready_after_done", W'(start_ready), W'(1));
            for (k = 0; k < 30; k++) begin
                a = rand_operand(); b = rand_operand();
                sub = 1'($urandom); cin = 1'($urandom);
                @(negedge clk);
                if (done) break;
            end
            check("b2b_second_done_seen", W'(k < 30), W'(1));
        end
        start_valid = 1'b0;

        // reset while RUN holds idx=2
        wait_idle("abort");
        a = 32'h11111111; b = 32'h22222222; sub = 1'b0; cin = 1'b0; start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_ready", W'(start_ready), W'(1));
        check("abort_result", result, '0);
        begin
            int seen = 0;
            repeat (8) begin
                @(negedge clk);
                if (done) seen++;
            end
            check("abort_no_done", W'(seen), W'(0));
        end
        run_op("after_abort", 32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0, 1'b0, 1'b0);

        // randomized traffic with occasional resets
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            start_valid = ($urandom_range(0, 3) != 0);
            a     = rand_operand();
            b     = rand_operand();
            sub   = 1'($urandom);
            cin   = 1'($urandom);
            reset = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk);
        reset = 1'b0; start_valid = 1'b0;
        repeat (NB + 4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
